riscv_core_branch_redirect_ctrl: RTL and testbench
==================================================

# riscv_core_branch_redirect_ctrl

Sequencing controller for branch/jump resolution in the execute stage. It accepts one resolved-operand branch or jump per handshake and evaluates the condition through an internal `riscv_core_branch_unit` instance. It compares the architectural next PC against the front-end prediction, then issues a fetch redirect plus a front-end flush on mispredict, or an instruction-address-misaligned exception request on a bad target. It also keeps a saturating mispredict counter for performance monitoring.

## Interface
- `XLEN`, 64, datapath and PC width
- `CNT_W`, 32, mispredict counter width
- `i_clk` in 1 — core clock
- `i_rst_n` in 1 — reset, asynchronous, active-low
- `i_bru_valid` in 1 — branch/jump request valid
- `o_bru_ready` out 1 — controller can accept a request
- `i_bru_type` in 2 — 2'b00 conditional branch, 2'b01 JAL, 2'b10 JALR, 2'b11 reserved (treated as not-taken branch)
- `i_bru_funct3` in 3 — branch condition
- `i_bru_srcA` in XLEN — rs1 value
- `i_bru_srcB` in XLEN — rs2 value
- `i_bru_pc` in XLEN — PC of the instruction
- `i_bru_target` in XLEN — computed taken target; JALR LSB already cleared
- `i_bru_is_rvc` in 1 — instruction is compressed (2 bytes)
- `i_bru_pred_pc` in XLEN — next PC the front end fetched
- `i_kill` in 1 — higher-priority pipeline kill from trap/commit logic
- `o_redir_valid` out 1 — redirect request to fetch
- `i_redir_ready` in 1 — fetch accepts redirect
- `o_redir_pc` out XLEN — redirect PC
- `o_flush` out 1 — one-cycle flush of IF/ID
- `o_exc_valid` out 1 — misaligned-target exception request
- `o_exc_tval` out XLEN — faulting target address
- `i_exc_ack` in 1 — trap unit accepted exception
- `o_busy` out 1 — state != IDLE
- `o_mispredict_cnt` out CNT_W — saturating mispredict count

## Operation
- The FSM has states IDLE, RESOLVE, REDIRECT and EXC. Reset state is IDLE.
- `o_bru_ready` = (state == IDLE) & ~`i_kill`. On `i_bru_valid` & `o_bru_ready`, all request fields are registered and the FSM moves to RESOLVE.
- RESOLVE is evaluated combinationally from the registered fields.
  - taken = branch-unit result for type 00; taken = 1 for JAL and JALR.
  - next_pc = taken ? target : pc + (is_rvc ? 2 : 4). The addition is modulo 2^XLEN, so wrap-around is allowed.
  - misaligned = taken & target[0]. IALIGN is 16 because C is implemented.
  - mispredict = (next_pc != pred_pc).
- RESOLVE transitions:
  - misaligned → EXC. This takes priority over mispredict. The counter is not updated.
  - else mispredict → REDIRECT. The counter increments and saturates at all-ones.
  - else → IDLE.
- REDIRECT:
  - `o_redir_valid` = ~`i_kill`.
  - `o_redir_pc` = registered next_pc, held stable until the handshake.
  - On `i_redir_ready` & `o_redir_valid`, the FSM moves to IDLE.
- EXC:
  - `o_exc_valid` = ~`i_kill`.
  - `o_exc_tval` = registered target.
  - On `i_exc_ack`, the FSM moves to IDLE.
- `o_flush` is a registered pulse, high for exactly the first cycle of REDIRECT or EXC.
- `i_kill` in any non-IDLE state forces IDLE at the next edge. A pending redirect or exception is dropped, and any flush already scheduled is suppressed. Kill has priority over a same-cycle `i_redir_ready` or `i_exc_ack`, so no handshake completes.
- Reset mid-operation: immediate return to IDLE. All outputs go to their reset values.
- Output reset values: `o_bru_ready` 1, `o_redir_valid` 0, `o_redir_pc` 0, `o_flush` 0, `o_exc_valid` 0, `o_exc_tval` 0, `o_busy` 0, `o_mispredict_cnt` 0.

## Timing
- Accept at edge N, resolve in cycle N+1, decision at edge N+2.
- On a mispredict or misaligned target, `o_flush`, `o_redir_valid` and `o_exc_valid` all first assert in cycle N+2.
- Correct prediction: throughput is one branch per 2 cycles.
- Mispredict: minimum 3 cycles from accept to ready again, plus any fetch backpressure.
- `o_redir_valid`, once asserted, may drop only on `i_kill`. `o_redir_pc` must not change while `o_redir_valid` is high.
- `o_mispredict_cnt` updates at the RESOLVE→REDIRECT edge and is visible from cycle N+2.

## Structure
- Shared package `riscv_core_pkg` holds:
  - `bru_type_e` enum: BR, JAL, JALR, RSVD
  - `bru_state_e` enum: IDLE, RESOLVE, REDIRECT, EXC
  - funct3 constants: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111
- One sub-module: `riscv_core_branch_unit`, driven from the registered srcA, srcB, funct3 and target[1:0].
  - Its istaken output is used.
  - Its address-mismatch output is left unconnected; the misaligned check above is authoritative.

## Test plan
- **BEQ taken, correctly predicted:** srcA=srcB=5, pc=0x1000, target=0x1040, pred_pc=0x1040 → no flush, no redirect, counter stays 0, ready again at N+2.
- **BLT not taken, mispredicted:** srcA=5, srcB=−3, is_rvc=1, pc=0x2000, pred_pc=0x2100 → flush pulse at N+2, redirect to 0x2002, counter 1.
- **Fetch backpressure:** JALR target=0x3000, pred_pc=0x0, `i_redir_ready` low for 4 cycles → `o_redir_valid` held with pc 0x3000 throughout, flush exactly 1 cycle, IDLE after the handshake.
- **Misaligned JAL:** target=0x4001 → EXC at N+2, `o_exc_tval`=0x4001, flush pulse, no redirect, counter unchanged, IDLE after `i_exc_ack`.
- **Kill in REDIRECT:** `i_kill` asserted in the same cycle as `i_redir_ready` → no handshake, IDLE next cycle. A separate case asserts kill in RESOLVE on a mispredict → no flush, counter still increments.
- **Wrap and saturation:** pc=0xFFFF_FFFF_FFFF_FFFC, not taken, non-RVC → next_pc=0. With CNT_W=4 and 17 mispredicts → counter holds 15.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the core's branch/jump resolution logic.
package riscv_core_pkg;

  // Kind of control-transfer instruction handed over by the execute stage.
  typedef enum logic [1:0] {
    BR   = 2'b00,
    JAL  = 2'b01,
    JALR = 2'b10,
    RSVD = 2'b11
  } bru_type_e;

  // Sequencing states of the redirect controller.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RESOLVE  = 2'b01,
    REDIRECT = 2'b10,
    EXC      = 2'b11
  } bru_state_e;

  // Conditional-branch funct3 encodings.
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

endpackage

// File: rtl/riscv_core_branch_redirect_ctrl_if.sv
// Request / redirect / exception bundle between execute, fetch and trap logic.
interface riscv_core_branch_redirect_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);

  logic              i_bru_valid;
  logic              o_bru_ready;
  logic [1:0]        i_bru_type;
  logic [2:0]        i_bru_funct3;
  logic [XLEN-1:0]   i_bru_srcA;
  logic [XLEN-1:0]   i_bru_srcB;
  logic [XLEN-1:0]   i_bru_pc;
  logic [XLEN-1:0]   i_bru_target;
  logic              i_bru_is_rvc;
  logic [XLEN-1:0]   i_bru_pred_pc;
  logic              i_kill;
  logic              o_redir_valid;
  logic              i_redir_ready;
  logic [XLEN-1:0]   o_redir_pc;
  logic              o_flush;
  logic              o_exc_valid;
  logic [XLEN-1:0]   o_exc_tval;
  logic              i_exc_ack;
  logic              o_busy;
  logic [CNT_W-1:0]  o_mispredict_cnt;

  // Pipeline side: issues requests, kill, and the fetch/trap responses.
  modport master (
    output i_bru_valid, i_bru_type, i_bru_funct3, i_bru_srcA, i_bru_srcB,
           i_bru_pc, i_bru_target, i_bru_is_rvc, i_bru_pred_pc, i_kill,
           i_redir_ready, i_exc_ack,
    input  o_bru_ready, o_redir_valid, o_redir_pc, o_flush, o_exc_valid,
           o_exc_tval, o_busy, o_mispredict_cnt
  );

  // Controller side.
  modport slave (
    input  i_bru_valid, i_bru_type, i_bru_funct3, i_bru_srcA, i_bru_srcB,
           i_bru_pc, i_bru_target, i_bru_is_rvc, i_bru_pred_pc, i_kill,
           i_redir_ready, i_exc_ack,
    output o_bru_ready, o_redir_valid, o_redir_pc, o_flush, o_exc_valid,
           o_exc_tval, o_busy, o_mispredict_cnt
  );

endinterface

// File: rtl/riscv_core_branch_unit.sv
// Pure-combinational branch condition evaluator.
module riscv_core_branch_unit
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_target_lo,
  output logic            o_istaken,
  output logic            o_addr_mismatch
);

  // Evaluate the funct3 condition; unused encodings never take.
  always_comb begin
    o_istaken = 1'b0;
    unique case (i_funct3)
      BEQ:     o_istaken = (i_src_a == i_src_b);
      BNE:     o_istaken = (i_src_a != i_src_b);
      BLT:     o_istaken = ($signed(i_src_a) <  $signed(i_src_b));
      BGE:     o_istaken = ($signed(i_src_a) >= $signed(i_src_b));
      BLTU:    o_istaken = (i_src_a <  i_src_b);
      BGEU:    o_istaken = (i_src_a >= i_src_b);
      default: o_istaken = 1'b0;
    endcase
  end

  // Target not 4-byte aligned (only meaningful for cores without C).
  assign o_addr_mismatch = |i_target_lo;

endmodule

// File: rtl/riscv_core_branch_redirect_ctrl.sv
// Execute-stage branch/jump resolution: compares the architectural next PC
// with the front-end prediction and issues redirect+flush or a misaligned
// target exception, while counting mispredicts.
module riscv_core_branch_redirect_ctrl
  import riscv_core_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  riscv_core_branch_redirect_ctrl_if.slave   bus
);

  bru_state_e        state_q,     state_d;
  bru_type_e         type_q,      type_d;
  logic [2:0]        funct3_q,    funct3_d;
  logic [XLEN-1:0]   src_a_q,     src_a_d;
  logic [XLEN-1:0]   src_b_q,     src_b_d;
  logic [XLEN-1:0]   pc_q,        pc_d;
  logic [XLEN-1:0]   target_q,    target_d;
  logic              is_rvc_q,    is_rvc_d;
  logic [XLEN-1:0]   pred_pc_q,   pred_pc_d;
  logic [XLEN-1:0]   redir_pc_q,  redir_pc_d;
  logic [XLEN-1:0]   exc_tval_q,  exc_tval_d;
  logic              flush_q,     flush_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic              bru_ready;
  logic              br_taken;
  logic              addr_mis_unused;
  logic              taken;
  logic [XLEN-1:0]   seq_pc;
  logic [XLEN-1:0]   next_pc;
  logic              misaligned;
  logic              mispredict;

  riscv_core_branch_unit #(.XLEN(XLEN)) u_branch_unit (
    .i_src_a         (src_a_q),
    .i_src_b         (src_b_q),
    .i_funct3        (funct3_q),
    .i_target_lo     (target_q[1:0]),
    .o_istaken       (br_taken),
    .o_addr_mismatch (addr_mis_unused)
  );

  assign bru_ready = (state_q == IDLE) & ~bus.i_kill;

  // Resolve the registered request: direction, architectural next PC, checks.
  always_comb begin
    taken = 1'b0;
    unique case (type_q)
      BR:      taken = br_taken;
      JAL:     taken = 1'b1;
      JALR:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
    seq_pc     = pc_q + (is_rvc_q ? XLEN'(2) : XLEN'(4));
    next_pc    = taken ? target_q : seq_pc;
    misaligned = taken & target_q[0];
    mispredict = (next_pc != pred_pc_q);
  end

  // Next-state and register-update logic for the sequencing FSM.
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    funct3_d   = funct3_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    pc_d       = pc_q;
    target_d   = target_q;
    is_rvc_d   = is_rvc_q;
    pred_pc_d  = pred_pc_q;
    redir_pc_d = redir_pc_q;
    exc_tval_d = exc_tval_q;
    flush_d    = 1'b0;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_bru_valid && bru_ready) begin
          type_d    = bru_type_e'(bus.i_bru_type);
          funct3_d  = bus.i_bru_funct3;
          src_a_d   = bus.i_bru_srcA;
          src_b_d   = bus.i_bru_srcB;
          pc_d      = bus.i_bru_pc;
          target_d  = bus.i_bru_target;
          is_rvc_d  = bus.i_bru_is_rvc;
          pred_pc_d = bus.i_bru_pred_pc;
          state_d   = RESOLVE;
        end
      end
      RESOLVE: begin
        if (misaligned) begin
          if (bus.i_kill) begin
            state_d = IDLE;
          end else begin
            exc_tval_d = target_q;
            flush_d    = 1'b1;
            state_d    = EXC;
          end
        end else if (mispredict) begin
          if (!(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (bus.i_kill) begin
            state_d = IDLE;
          end else begin
            redir_pc_d = next_pc;
            flush_d    = 1'b1;
            state_d    = REDIRECT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REDIRECT: begin
        if (bus.i_kill || bus.i_redir_ready) begin
          state_d = IDLE;
        end
      end
      EXC: begin
        if (bus.i_kill || bus.i_exc_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      type_q     <= BR;
      funct3_q   <= '0;
      src_a_q    <= '0;
      src_b_q    <= '0;
      pc_q       <= '0;
      target_q   <= '0;
      is_rvc_q   <= 1'b0;
      pred_pc_q  <= '0;
      redir_pc_q <= '0;
      exc_tval_q <= '0;
      flush_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      funct3_q   <= funct3_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      is_rvc_q   <= is_rvc_d;
      pred_pc_q  <= pred_pc_d;
      redir_pc_q <= redir_pc_d;
      exc_tval_q <= exc_tval_d;
      flush_q    <= flush_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.o_bru_ready      = bru_ready;
  assign bus.o_redir_valid    = (state_q == REDIRECT) & ~bus.i_kill;
  assign bus.o_redir_pc       = redir_pc_q;
  assign bus.o_flush          = flush_q;
  assign bus.o_exc_valid      = (state_q == EXC) & ~bus.i_kill;
  assign bus.o_exc_tval       = exc_tval_q;
  assign bus.o_busy           = (state_q != IDLE);
  assign bus.o_mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_core_branch_redirect_ctrl.sv
// Self-checking bench for the branch redirect controller: directed cases with
// literal expectations plus a randomized run against a transaction-level model.
module tb_riscv_core_branch_redirect_ctrl;

  localparam int XLEN    = 64;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [1:0]  typ;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] pc;
    logic [63:0] tgt;
    logic        rvc;
    logic [63:0] pred;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   rand_mode = 1'b0;
  int   check_count = 0;
  int   error_count = 0;

  riscv_core_branch_redirect_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  riscv_core_branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Global time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its required value.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural outcome of one request, straight from the ISA rules.
  function automatic logic is_taken(input req_t r);
    if (r.typ == 2'b01 || r.typ == 2'b10) return 1'b1;
    if (r.typ != 2'b00) return 1'b0;
    case (r.f3)
      3'b000:  return r.a == r.b;
      3'b001:  return r.a != r.b;
      3'b100:  return $signed(r.a) <  $signed(r.b);
      3'b101:  return $signed(r.a) >= $signed(r.b);
      3'b110:  return r.a <  r.b;
      3'b111:  return r.a >= r.b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] resolved_pc(input req_t r);
    logic [63:0] step;
    step = r.rvc ? 64'd2 : 64'd4;
    return is_taken(r) ? r.tgt : r.pc + step;
  endfunction

  function automatic logic bad_target(input req_t r);
    return is_taken(r) && r.tgt[0];
  endfunction

  // Transaction-level model: 0 waiting, 1 resolving, 2 redirecting, 3 trapping.
  int          m_phase;
  logic        m_flush;
  int          m_cnt;
  logic [63:0] m_rpc;
  logic [63:0] m_tval;
  req_t        m_req;

  // Advance the model on each clock edge from the inputs of that cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_flush <= 1'b0;
      m_cnt   <= 0;
      m_rpc   <= '0;
      m_tval  <= '0;
    end else begin
      m_flush <= 1'b0;
      case (m_phase)
        0: if (bus.i_bru_valid && !bus.i_kill) begin
          m_req <= '{typ: bus.i_bru_type, f3: bus.i_bru_funct3, a: bus.i_bru_srcA,
                     b: bus.i_bru_srcB, pc: bus.i_bru_pc, tgt: bus.i_bru_target,
                     rvc: bus.i_bru_is_rvc, pred: bus.i_bru_pred_pc};
          m_phase <= 1;
        end
        1: if (bad_target(m_req)) begin
          m_tval  <= m_req.tgt;
          m_phase <= bus.i_kill ? 0 : 3;
          m_flush <= !bus.i_kill;
        end else if (resolved_pc(m_req) != m_req.pred) begin
          m_cnt   <= (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
          m_rpc   <= resolved_pc(m_req);
          m_phase <= bus.i_kill ? 0 : 2;
          m_flush <= !bus.i_kill;
        end else begin
          m_phase <= 0;
        end
        2: if (bus.i_kill || bus.i_redir_ready) m_phase <= 0;
        3: if (bus.i_kill || bus.i_exc_ack) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  // Every cycle, check all outputs against the model mid-cycle.
  always @(negedge clk) begin
    checkOutput("ready",     {63'd0, bus.o_bru_ready},   {63'd0, (m_phase == 0) && !bus.i_kill});
    checkOutput("redir_vld", {63'd0, bus.o_redir_valid}, {63'd0, (m_phase == 2) && !bus.i_kill});
    checkOutput("exc_vld",   {63'd0, bus.o_exc_valid},   {63'd0, (m_phase == 3) && !bus.i_kill});
    checkOutput("busy",      {63'd0, bus.o_busy},        {63'd0, m_phase != 0});
    checkOutput("flush",     {63'd0, bus.o_flush},       {63'd0, m_flush});
    checkOutput("cnt",       64'(bus.o_mispredict_cnt),  64'(m_cnt));
    if (m_phase == 2) checkOutput("redir_pc", bus.o_redir_pc, m_rpc);
    if (m_phase == 3) checkOutput("exc_tval", bus.o_exc_tval, m_tval);
  end

  // Random fetch/trap responses and occasional kills during the random run.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        bus.i_kill        = ($urandom_range(0, 15) == 0);
        bus.i_redir_ready = ($urandom_range(0, 2) != 0);
        bus.i_exc_ack     = ($urandom_range(0, 2) == 0);
      end
    end
  end

  // Present a request and hold it until an edge where the controller accepts.
  task automatic applyStimulus(input logic [1:0] typ, input logic [2:0] f3,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] pc, input logic [63:0] tgt,
                               input logic rvc, input logic [63:0] pred);
    bit accepted;
    int waited;
    bus.i_bru_valid   = 1'b1;
    bus.i_bru_type    = typ;
    bus.i_bru_funct3  = f3;
    bus.i_bru_srcA    = a;
    bus.i_bru_srcB    = b;
    bus.i_bru_pc      = pc;
    bus.i_bru_target  = tgt;
    bus.i_bru_is_rvc  = rvc;
    bus.i_bru_pred_pc = pred;
    accepted = 1'b0;
    waited   = 0;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      accepted = bus.o_bru_ready;
      @(posedge clk);
      waited++;
    end
    #1;
    bus.i_bru_valid = 1'b0;
    if (!accepted) begin
      check_count++;
      error_count++;
      $display("[TB] FAIL accept_timeout: got no ready, expected ready within 200 cycles");
    end
  endtask

  task automatic toDrivePoint();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    bus.i_bru_valid = 1'b0;
    bus.i_kill = 1'b0;
    bus.i_redir_ready = 1'b1;
    bus.i_exc_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    toDrivePoint();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"},     {63'd0, bus.o_bru_ready},   64'd1);
    checkOutput({tag, "_redir_vld"}, {63'd0, bus.o_redir_valid}, 64'd0);
    checkOutput({tag, "_redir_pc"},  bus.o_redir_pc,             64'd0);
    checkOutput({tag, "_flush"},     {63'd0, bus.o_flush},       64'd0);
    checkOutput({tag, "_exc_vld"},   {63'd0, bus.o_exc_valid},   64'd0);
    checkOutput({tag, "_exc_tval"},  bus.o_exc_tval,             64'd0);
    checkOutput({tag, "_busy"},      {63'd0, bus.o_busy},        64'd0);
    checkOutput({tag, "_cnt"},       64'(bus.o_mispredict_cnt),  64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb, rpc, rtgt, rpred;
    bus.i_bru_type = 2'b00; bus.i_bru_funct3 = 3'b000;
    bus.i_bru_srcA = '0; bus.i_bru_srcB = '0; bus.i_bru_pc = '0;
    bus.i_bru_target = '0; bus.i_bru_is_rvc = 1'b0; bus.i_bru_pred_pc = '0;
    resetDut();
    @(negedge clk);
    checkResetValues("rst");
    toDrivePoint();

    // BEQ taken, correctly predicted: back to ready at N+2.
    applyStimulus(2'b00, 3'b000, 64'd5, 64'd5, 64'h1000, 64'h1040, 1'b0, 64'h1040);
    @(negedge clk);
    checkOutput("beq_busy_n1", {63'd0, bus.o_busy}, 64'd1);
    @(negedge clk);
    checkOutput("beq_ready_n2", {63'd0, bus.o_bru_ready}, 64'd1);
    checkOutput("beq_flush_n2", {63'd0, bus.o_flush}, 64'd0);
    checkOutput("beq_cnt", 64'(bus.o_mispredict_cnt), 64'd0);
    toDrivePoint();

    // BLT not taken, compressed, mispredicted.
    applyStimulus(2'b00, 3'b100, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'h2000, 64'h2400, 1'b1, 64'h2100);
    @(negedge clk);
    @(negedge clk);
    checkOutput("blt_flush", {63'd0, bus.o_flush}, 64'd1);
    checkOutput("blt_redir_vld", {63'd0, bus.o_redir_valid}, 64'd1);
    checkOutput("blt_redir_pc", bus.o_redir_pc, 64'h2002);
    checkOutput("blt_cnt", 64'(bus.o_mispredict_cnt), 64'd1);
    @(negedge clk);
    checkOutput("blt_flush_off", {63'd0, bus.o_flush}, 64'd0);
    checkOutput("blt_idle", {63'd0, bus.o_busy}, 64'd0);
    toDrivePoint();

    // JALR with fetch backpressure for four cycles.
    bus.i_redir_ready = 1'b0;
    applyStimulus(2'b10, 3'b000, 64'd0, 64'd0, 64'h2800, 64'h3000, 1'b0, 64'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_flush", {63'd0, bus.o_flush}, 64'd1);
    checkOutput("bp_redir_pc", bus.o_redir_pc, 64'h3000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_vld", {63'd0, bus.o_redir_valid}, 64'd1);
      checkOutput("bp_hold_pc", bus.o_redir_pc, 64'h3000);
      checkOutput("bp_hold_flush", {63'd0, bus.o_flush}, 64'd0);
    end
    toDrivePoint();
    bus.i_redir_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_last_vld", {63'd0, bus.o_redir_valid}, 64'd1);
    @(negedge clk);
    checkOutput("bp_idle", {63'd0, bus.o_busy}, 64'd0);
    checkOutput("bp_cnt", 64'(bus.o_mispredict_cnt), 64'd2);
    toDrivePoint();

    // Misaligned JAL target raises the exception path.
    bus.i_exc_ack = 1'b0;
    applyStimulus(2'b01, 3'b000, 64'd0, 64'd0, 64'h3ffc, 64'h4001, 1'b0, 64'h4001);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mis_exc_vld", {63'd0, bus.o_exc_valid}, 64'd1);
    checkOutput("mis_tval", bus.o_exc_tval, 64'h4001);
    checkOutput("mis_flush", {63'd0, bus.o_flush}, 64'd1);
    checkOutput("mis_no_redir", {63'd0, bus.o_redir_valid}, 64'd0);
    checkOutput("mis_cnt", 64'(bus.o_mispredict_cnt), 64'd2);
    toDrivePoint();
    bus.i_exc_ack = 1'b1;
    @(negedge clk);
    checkOutput("mis_exc_hold", {63'd0, bus.o_exc_valid}, 64'd1);
    @(negedge clk);
    checkOutput("mis_idle", {63'd0, bus.o_busy}, 64'd0);
    toDrivePoint();
    bus.i_exc_ack = 1'b0;

    // Kill in REDIRECT together with redirect ready.
    bus.i_redir_ready = 1'b0;
    applyStimulus(2'b00, 3'b001, 64'd1, 64'd1, 64'h5000, 64'h5800, 1'b0, 64'h6000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("kr_redir_pc", bus.o_redir_pc, 64'h5004);
    checkOutput("kr_cnt", 64'(bus.o_mispredict_cnt), 64'd3);
    toDrivePoint();
    bus.i_kill = 1'b1;
    bus.i_redir_ready = 1'b1;
    @(negedge clk);
    checkOutput("kr_vld_killed", {63'd0, bus.o_redir_valid}, 64'd0);
    toDrivePoint();
    bus.i_kill = 1'b0;
    @(negedge clk);
    checkOutput("kr_idle", {63'd0, bus.o_busy}, 64'd0);
    checkOutput("kr_ready", {63'd0, bus.o_bru_ready}, 64'd1);
    toDrivePoint();

    // Kill in RESOLVE on a mispredict: no flush, counter still moves.
    applyStimulus(2'b01, 3'b000, 64'd0, 64'd0, 64'h6ffc, 64'h7000, 1'b0, 64'h7004);
    bus.i_kill = 1'b1;
    @(negedge clk);
    checkOutput("krs_ready_low", {63'd0, bus.o_bru_ready}, 64'd0);
    toDrivePoint();
    bus.i_kill = 1'b0;
    @(negedge clk);
    checkOutput("krs_no_flush", {63'd0, bus.o_flush}, 64'd0);
    checkOutput("krs_idle", {63'd0, bus.o_busy}, 64'd0);
    checkOutput("krs_cnt", 64'(bus.o_mispredict_cnt), 64'd4);
    toDrivePoint();

    // PC wrap-around on the fall-through path.
    applyStimulus(2'b00, 3'b001, 64'd7, 64'd7, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 1'b0, 64'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("wrap_ok_flush", {63'd0, bus.o_flush}, 64'd0);
    checkOutput("wrap_ok_idle", {63'd0, bus.o_busy}, 64'd0);
    toDrivePoint();
    applyStimulus(2'b00, 3'b001, 64'd7, 64'd7, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 1'b0, 64'h8);
    @(negedge clk);
    @(negedge clk);
    checkOutput("wrap_redir_pc", bus.o_redir_pc, 64'h0);
    checkOutput("wrap_cnt", 64'(bus.o_mispredict_cnt), 64'd5);
    toDrivePoint();

    // Twelve more mispredicts: seventeen total saturates a 4-bit counter.
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(2'b00, 3'b000, 64'd1, 64'd2, 64'(i) << 8, 64'h0, 1'b0, 64'h0);
      repeat (3) @(negedge clk);
      toDrivePoint();
    end
    @(negedge clk);
    checkOutput("sat_cnt", 64'(bus.o_mispredict_cnt), 64'd15);
    toDrivePoint();

    // Randomized run against the model.
    resetDut();
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      ra  = {$urandom, $urandom};
      rb  = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
      rpc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : ({$urandom, $urandom} & ~64'h1);
      rtgt = ({$urandom, $urandom} & ~64'h1) | 64'($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       rpred = rtgt;
        1:       rpred = rpc + 64'd2;
        2:       rpred = rpc + 64'd4;
        default: rpred = {$urandom, $urandom};
      endcase
      applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), ra, rb, rpc, rtgt,
                    1'($urandom_range(0, 1)), rpred);
      repeat ($urandom_range(0, 2)) toDrivePoint();
    end
    rand_mode = 1'b0;
    toDrivePoint();
    bus.i_kill = 1'b0;
    bus.i_redir_ready = 1'b1;
    bus.i_exc_ack = 1'b1;
    repeat (4) toDrivePoint();
    bus.i_exc_ack = 1'b0;

    // Asynchronous reset while a redirect is pending.
    bus.i_redir_ready = 1'b0;
    applyStimulus(2'b10, 3'b000, 64'd0, 64'd0, 64'h9000, 64'hA000, 1'b0, 64'h9004);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mr_pending", {63'd0, bus.o_redir_valid}, 64'd1);
    toDrivePoint();
    rst_n = 1'b0;
    #2;
    checkResetValues("midrst");
    toDrivePoint();
    rst_n = 1'b1;
    bus.i_redir_ready = 1'b1;
    repeat (2) toDrivePoint();

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
